// File: rtl/hit_judge.sv
// Whack-a-mole player input: synchronizes and debounces four buttons, judges each
// press against the displayed mole, and keeps a saturating two-digit BCD score.
module hit_judge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       RESTART,
  input  logic [3:0] btn,
  input  logic [3:0] mole_an,
  input  logic       SWITCH,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic       clear_mole,
  output logic [3:0] last_btn,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ARMED,
    LOCKOUT
  } state_t;

  state_t           state;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       stable;
  logic [3:0]       stable_d;
  logic [CNT_W-1:0] cnt [4];

  logic [3:0]       press;
  logic             single_press;
  logic             is_hit;
  logic [3:0]       up_tens;
  logic [3:0]       up_ones;
  logic [3:0]       dn_tens;
  logic [3:0]       dn_ones;

  always_ff @(posedge clk or posedge RESTART) begin
    if (RESTART) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge RESTART) begin
    if (RESTART) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != stable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            stable[i] <= sync2[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press        = stable & ~stable_d;
  assign single_press = (press != 4'd0) && ((press & (press - 4'd1)) == 4'd0);
  assign is_hit       = single_press && ((press & ~mole_an) != 4'd0);

  // Saturating BCD increment/decrement candidates for the current score.
  always_comb begin
    up_tens = score_tens;
    up_ones = score_ones;
    dn_tens = score_tens;
    dn_ones = score_ones;
    if (!(score_tens == 4'd9 && score_ones == 4'd9)) begin
      if (score_ones == 4'd9) begin
        up_ones = 4'd0;
        up_tens = score_tens + 4'd1;
      end else begin
        up_ones = score_ones + 4'd1;
      end
    end
    if (!(score_tens == 4'd0 && score_ones == 4'd0)) begin
      if (score_ones == 4'd0) begin
        dn_ones = 4'd9;
        dn_tens = score_tens - 4'd1;
      end else begin
        dn_ones = score_ones - 4'd1;
      end
    end
  end

  // One judgement per press burst; LOCKOUT waits for every button to be released.
  always_ff @(posedge clk or posedge RESTART) begin
    if (RESTART) begin
      state      <= ARMED;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      clear_mole <= 1'b0;
      last_btn   <= '0;
      score_tens <= '0;
      score_ones <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      clear_mole <= 1'b0;
      case (state)
        ARMED: begin
          if (!SWITCH && press != 4'd0) begin
            last_btn <= press;
            state    <= LOCKOUT;
            if (is_hit) begin
              hit_pulse  <= 1'b1;
              clear_mole <= 1'b1;
              score_tens <= up_tens;
              score_ones <= up_ones;
            end else begin
              miss_pulse <= 1'b1;
              score_tens <= dn_tens;
              score_ones <= dn_ones;
            end
          end
        end
        LOCKOUT: begin
          if (stable == 4'd0) begin
            state <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Scoreboard bench for hit_judge: stimulus pushes expected judgements, a monitor
// pops and compares them whenever the DUT strobes hit or miss.
module tb_hit_judge;

  logic       clk = 1'b0;
  logic       RESTART = 1'b1;
  logic [3:0] btn = 4'd0;
  logic [3:0] mole_an = 4'hF;
  logic       SWITCH = 1'b0;
  logic       hit_pulse;
  logic       miss_pulse;
  logic       clear_mole;
  logic [3:0] last_btn;
  logic [3:0] score_tens;
  logic [3:0] score_ones;

  typedef struct {
    logic       hit;
    logic [3:0] btn;
    int         score;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails = 0;
  int   model_score = 0;

  hit_judge #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk        (clk),
    .RESTART    (RESTART),
    .btn        (btn),
    .mole_an    (mole_an),
    .SWITCH     (SWITCH),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .clear_mole (clear_mole),
    .last_btn   (last_btn),
    .score_tens (score_tens),
    .score_ones (score_ones)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Game rules: one button on a lit digit scores, anything else costs a point.
  function automatic void model_judge(input logic [3:0] mask, input logic [3:0] mole);
    exp_t e;
    e.btn = mask;
    if ($countones(mask) == 1 && (mask & ~mole) != 4'd0) begin
      e.hit = 1'b1;
      if (model_score < 99) model_score++;
    end else begin
      e.hit = 1'b0;
      if (model_score > 0) model_score--;
    end
    e.score = model_score;
    q.push_back(e);
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
    checkOutput(name, q.size(), 0);
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input logic [3:0] mole, input logic sw);
    mole_an = mole;
    SWITCH  = sw;
    if (!sw) model_judge(mask, mole);
    btn = mask;
    idle(14);
    if (!sw) wait_drain("judge_latency");
    btn = 4'd0;
    idle(14);
    SWITCH = 1'b0;
  endtask

  task automatic random_hit();
    logic [3:0] mask;
    logic [3:0] mole;
    mask = 4'd1 << $urandom_range(0, 3);
    mole = 4'($urandom) & ~mask;
    applyStimulus(mask, mole, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    logic strobe;
    logic prev_strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (!RESTART) begin
        strobe = hit_pulse | miss_pulse;
        checkOutput("clear_vs_hit", clear_mole, hit_pulse);
        if (strobe) begin
          checkOutput("strobe_width", prev_strobe, 0);
          if (q.size() == 0) begin
            checkOutput("unexpected_strobe", strobe, 0);
          end else begin
            e = q.pop_front();
            checkOutput("hit", hit_pulse, e.hit);
            checkOutput("miss", miss_pulse, !e.hit);
            checkOutput("last_btn", last_btn, e.btn);
            checkOutput("score", score_tens * 10 + score_ones, e.score);
          end
        end
        prev_strobe = strobe;
      end else begin
        prev_strobe = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] mask;
    logic [3:0] mole;
    logic       sw;
    int         r;

    idle(3);
    RESTART = 1'b0;
    idle(1);
    checkOutput("reset_hit", hit_pulse, 0);
    checkOutput("reset_miss", miss_pulse, 0);
    checkOutput("reset_clear", clear_mole, 0);
    checkOutput("reset_last_btn", last_btn, 0);
    checkOutput("reset_score", score_tens * 10 + score_ones, 0);

    applyStimulus(4'b0010, 4'b1111, 1'b0);
    applyStimulus(4'b0001, 4'b1110, 1'b0);

    // Bounce shorter than the debounce window must not create extra presses.
    mole_an = 4'b1011;
    model_judge(4'b0100, 4'b1011);
    for (int k = 0; k < 4; k++) begin
      btn = 4'b0100;
      idle(2);
      btn = 4'b0000;
      idle(2);
    end
    btn = 4'b0100;
    idle(14);
    wait_drain("bounce_hit");
    btn = 4'b0000;
    idle(14);

    // Anti-mash, then a held button cannot be re-judged without a full release.
    mole_an = 4'b1110;
    model_judge(4'b0101, 4'b1110);
    btn = 4'b0101;
    idle(14);
    wait_drain("multi_press");
    btn = 4'b0001;
    idle(14);
    btn = 4'b0000;
    idle(14);
    applyStimulus(4'b0001, 4'b1110, 1'b0);

    for (int n = 0; n < 40; n++) begin
      mask = 4'($urandom_range(1, 15));
      r = $urandom_range(0, 2);
      if (r == 0) mole = ~(4'd1 << $urandom_range(0, 3));
      else if (r == 1) mole = 4'hF;
      else mole = 4'($urandom);
      sw = ($urandom_range(0, 4) == 0);
      applyStimulus(mask, mole, sw);
    end

    while (model_score < 99) random_hit();
    random_hit();
    applyStimulus(4'b0010, 4'b1111, 1'b0);
    checkOutput("score_98", score_tens * 10 + score_ones, 98);

    RESTART = 1'b1;
    idle(2);
    RESTART = 1'b0;
    model_score = 0;
    idle(2);
    for (int n = 0; n < 10; n++) random_hit();
    checkOutput("tens_carry", score_tens, 1);
    checkOutput("ones_carry", score_ones, 0);

    applyStimulus(4'b0001, 4'b1110, 1'b1);

    // Reset while locked out; the still-held button is judged again afterwards.
    mole_an = 4'b1110;
    model_judge(4'b0001, 4'b1110);
    btn = 4'b0001;
    idle(14);
    wait_drain("pre_reset_hit");
    RESTART = 1'b1;
    #1;
    checkOutput("restart_score", score_tens * 10 + score_ones, 0);
    checkOutput("restart_last_btn", last_btn, 0);
    model_score = 0;
    idle(2);
    RESTART = 1'b0;
    model_judge(4'b0001, 4'b1110);
    idle(14);
    wait_drain("held_through_reset");
    btn = 4'b0000;
    idle(14);
    applyStimulus(4'b0001, 4'b1110, 1'b0);

    checkOutput("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
